// File: rtl/cache_victim_sel.sv
// Cache victim-way selector: invalid-first, then LFSR-random or per-set round-robin.
// VictimWay is combinational; the read pointer and LFSR are registered one cycle ahead.
module cache_victim_sel #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128,
  parameter int LFSRLEN  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheEn,
  input  logic               FlushStage,
  input  logic [1:0]         PolicyMode,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSetData,
  input  logic [SETLEN-1:0]  CacheSetTag,
  input  logic               LRUWriteEn,
  input  logic               InvalidateCache,
  input  logic               SeedEn,
  input  logic [LFSRLEN-1:0] Seed,
  output logic [NUMWAYS-1:0] VictimWay
);

  // Maximal-length tap sets, bit positions 0-based, feedback shifted into bit 0.
  function automatic logic [15:0] tap_mask(input int len);
    case (len)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  localparam logic [15:0] TAPS = tap_mask(LFSRLEN);

  logic [LFSRLEN-1:0] lfsr;
  logic               fb;

  assign fb = ^(lfsr & TAPS[LFSRLEN-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSRLEN'(1);
    end else if (SeedEn) begin
      lfsr <= (Seed == '0) ? LFSRLEN'(1) : Seed;
    end else if (CacheEn && !FlushStage) begin
      lfsr <= {lfsr[LFSRLEN-2:0], fb};
    end
  end

  generate
    if (NUMWAYS == 1) begin : g_single
      assign VictimWay = 1'b1;
    end else begin : g_multi
      localparam int WW = $clog2(NUMWAYS);
      localparam int LW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;

      logic [WW-1:0] ptr [NUMLINES];
      logic [WW-1:0] rdptr;
      logic [WW-1:0] wr_val;
      logic [WW-1:0] rd_val;
      logic [LW-1:0] tag_idx;
      logic [LW-1:0] data_idx;
      logic          tag_ok;
      logic          data_ok;
      logic          allvalid;
      logic          wr_en;
      logic          bypass;
      logic          found;

      assign allvalid = &ValidWay;
      assign tag_idx  = CacheSetTag[LW-1:0];
      assign data_idx = CacheSetData[LW-1:0];
      assign tag_ok   = int'(CacheSetTag) < NUMLINES;
      assign data_ok  = int'(CacheSetData) < NUMLINES;
      assign wr_en    = LRUWriteEn && !FlushStage && allvalid && (PolicyMode == 2'b01);
      assign wr_val   = rdptr + WW'(1);
      assign rd_val   = data_ok ? ptr[data_idx] : '0;
      // A fill to the set being read must be visible to that read.
      assign bypass   = wr_en && (CacheSetTag == CacheSetData);

      always_ff @(posedge clk) begin
        if (reset || InvalidateCache) begin
          for (int i = 0; i < NUMLINES; i++) ptr[i] <= '0;
          rdptr <= '0;
        end else begin
          if (wr_en && tag_ok) ptr[tag_idx] <= wr_val;
          if (CacheEn && !FlushStage) rdptr <= bypass ? wr_val : rd_val;
        end
      end

      always_comb begin
        VictimWay = '0;
        found     = 1'b0;
        if (!allvalid) begin
          for (int i = 0; i < NUMWAYS; i++) begin
            if (!ValidWay[i] && !found) begin
              VictimWay[i] = 1'b1;
              found        = 1'b1;
            end
          end
        end else if (PolicyMode == 2'b01) begin
          VictimWay[rdptr] = 1'b1;
        end else begin
          VictimWay[lfsr[WW-1:0]] = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: doc/cache_victim_sel.md
CACHE_VICTIM_SEL -- requirements
Module: cache_victim_sel

Interface
REQ-001 Parameter NUMWAYS, default 4: ways per set; power of two, 1..16.
REQ-002 Parameter SETLEN, default 9: set-index width.
REQ-003 Parameter NUMLINES, default 128: sets tracked; equals 2^SETLEN or less.
REQ-004 Parameter LFSRLEN, default 8: LFSR width; legal 4..16; SHALL be at least log2(NUMWAYS)+2.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 CacheEn  in  1  enables set read and LFSR advance; 0 holds read state.
REQ-008 FlushStage  in  1  suppresses all policy-state updates this cycle.
REQ-009 PolicyMode  in  2  00 random (LFSR), 01 per-set round-robin, 10/11 treated as 00.
REQ-010 ValidWay  in  NUMWAYS  valid bits of the set read last cycle.
REQ-011 CacheSetData  in  SETLEN  set index being read (victim for next cycle).
REQ-012 CacheSetTag  in  SETLEN  set index being filled (update target).
REQ-013 LRUWriteEn  in  1  fill commits this cycle; advance policy state.
REQ-014 InvalidateCache  in  1  clear all round-robin pointers.
REQ-015 SeedEn  in  1  load LFSR from Seed.
REQ-016 Seed  in  LFSRLEN  LFSR load value.
REQ-017 VictimWay  out  NUMWAYS  one-hot way to evict.

Function
REQ-018 LFSR SHALL be a maximal-length Fibonacci LFSR of LFSRLEN bits, one fixed tap table entry per legal LFSRLEN.
REQ-019 LFSR SHALL advance one step each cycle CacheEn=1 and FlushStage=0, otherwise hold.
REQ-020 SeedEn=1 SHALL load Seed, overriding advance; Seed=0 SHALL load 1 (all-zero lock-up forbidden).
REQ-021 Round-robin state SHALL be NUMLINES pointers of log2(NUMWAYS) bits.
REQ-022 When CacheEn=1, pointer[CacheSetData] SHALL be registered into RdPtr; CacheEn=0 holds RdPtr.
REQ-023 If same cycle writes pointer[CacheSetTag] with CacheSetTag==CacheSetData, RdPtr SHALL capture the new value (write-to-read bypass).
REQ-024 AllValid = &ValidWay; if AllValid=0, VictimWay SHALL be one-hot of lowest-index zero in ValidWay, independent of mode.
REQ-025 If AllValid=1: mode random -> way LFSR[log2(NUMWAYS)-1:0]; mode round-robin -> way RdPtr.
REQ-026 VictimWay SHALL be combinational from ValidWay, PolicyMode, RdPtr, LFSR; always exactly one bit set.
REQ-027 On LRUWriteEn=1, FlushStage=0, AllValid=1, PolicyMode=01: pointer[CacheSetTag] <= RdPtr+1 mod NUMWAYS (wraps NUMWAYS-1 -> 0).
REQ-028 Fill into an invalid way (AllValid=0) or in random mode SHALL leave pointers unchanged.
REQ-029 InvalidateCache=1 SHALL clear every pointer and RdPtr to 0 in one cycle, priority over REQ-027; LFSR unaffected.
REQ-030 FlushStage=1 SHALL block REQ-019, REQ-022 and REQ-027 but not REQ-020 or REQ-029.
REQ-031 NUMWAYS=1: VictimWay SHALL be constant 1; no pointer storage required.
REQ-032 PolicyMode change SHALL take effect on VictimWay combinationally, with no state clear.

Reset
REQ-033 reset SHALL set LFSR=1, all pointers=0, RdPtr=0; reset overrides SeedEn, InvalidateCache, LRUWriteEn.
REQ-034 After reset, 4-way, ValidWay=0000 -> VictimWay=0001; ValidWay=1111 -> mode 00 gives 0010, mode 01 gives 0001.
REQ-035 Reset asserted mid-fill SHALL discard that fill's pointer update.

Verification
REQ-036 4-way, mode 01, ValidWay=1111, four fills to set 5 with CacheSetData=5 -> VictimWay 0001,0010,0100,1000, then 0001 (wrap).
REQ-037 ValidWay=1011 in either mode -> VictimWay=0100; fill leaves pointer[5] unchanged.
REQ-038 LFSRLEN=8, free-run CacheEn=1 -> LFSR returns to 1 after exactly 255 cycles, never 0; SeedEn with Seed=0 -> LFSR=1.
REQ-039 Fill set 5 with CacheSetData=5 same cycle, pointer 2 -> RdPtr=3 next cycle (bypass).
REQ-040 FlushStage=1 with LRUWriteEn=1 -> pointer and LFSR unchanged; InvalidateCache after pointers set -> all sets report way 0.
REQ-041 Sweep NUMWAYS 1,2,8,16: random mode over 10k cycles hits every way; VictimWay one-hot every cycle.
